// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcodes, status flags, buffer states.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101
  } opcode_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // ADD and SUB are the only opcodes whose adder flags are meaningful.
  function automatic logic is_arith(input logic [2:0] opcode);
    return opcode[2:1] == 2'b00;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream valid-ready bus of the ALU result stage.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opcode;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;

  // Environment side: drives ALU results in and consumes entries.
  modport master (
    output in_valid, in_opcode, in_result, in_carry, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  // Stage side.
  modport slave (
    input  in_valid, in_opcode, in_result, in_carry, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation; adder-derived flags are masked for logical ops.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  output alu_flags_t       flags
);

  logic arith;

  // Z is reported for every opcode; N/C/V only for ADD/SUB.
  always_comb begin
    arith   = is_arith(opcode);
    flags   = '0;
    flags.n = result[WIDTH-1] & arith;
    flags.z = (result == '0);
    flags.c = carry & arith;
    flags.v = overflow & arith;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage: 2-entry skid FIFO with stored flags and a
// saturating overflow-event counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_stage_if.slave    bus,
  input  logic                 ovf_clear,
  output logic [CNT_W-1:0]     ovf_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  buf_state_t       state_q, state_d;
  logic [WIDTH-1:0] head_result_q, tail_result_q;
  alu_flags_t       head_flags_q, tail_flags_q;
  logic [CNT_W-1:0] ovf_q;
  alu_flags_t       new_flags;
  logic             push, pop;
  logic             load_head_new, load_tail_new, shift_tail;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .opcode   (bus.in_opcode),
    .result   (bus.in_result),
    .carry    (bus.in_carry),
    .overflow (bus.in_overflow),
    .flags    (new_flags)
  );

  // Handshake outputs depend only on registered state.
  assign bus.in_ready   = (state_q != FULL);
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_result = head_result_q;
  assign bus.out_flags  = head_flags_q;
  assign ovf_count      = ovf_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Buffer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state and entry-move controls.
  always_comb begin
    state_d       = state_q;
    load_head_new = 1'b0;
    load_tail_new = 1'b0;
    shift_tail    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          load_head_new = 1'b1;
          state_d       = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // New entry replaces the departing head.
          load_head_new = 1'b1;
        end else if (push) begin
          load_tail_new = 1'b1;
          state_d       = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          shift_tail = 1'b1;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Entry storage; head is what drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_result_q <= '0;
      head_flags_q  <= '0;
      tail_result_q <= '0;
      tail_flags_q  <= '0;
    end else begin
      if (load_head_new) begin
        head_result_q <= bus.in_result;
        head_flags_q  <= new_flags;
      end else if (shift_tail) begin
        head_result_q <= tail_result_q;
        head_flags_q  <= tail_flags_q;
      end
      if (load_tail_new) begin
        tail_result_q <= bus.in_result;
        tail_flags_q  <= new_flags;
      end
    end
  end

  // Saturating overflow counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (ovf_clear) begin
      ovf_q <= '0;
    end else if (push && new_flags.v && (ovf_q != CntMax)) begin
      ovf_q <= ovf_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ovf_clear;
  logic [7:0] ovf_count;
  int         checks;
  int         passes;
  int         fails;

  alu_result_stage_if #(.WIDTH(16)) bus ();

  alu_result_stage #(
    .WIDTH (16),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ovf_clear (ovf_clear),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [2:0] op, input logic [15:0] res,
                       input logic c, input logic v);
    bus.in_valid    = valid;
    bus.in_opcode   = op;
    bus.in_result   = res;
    bus.in_carry    = c;
    bus.in_overflow = v;
  endtask

  // Advance past one rising edge; checks happen 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    rst_n         = 1'b0;
    ovf_clear     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0);

    // Reset state
    #3;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_result", {16'b0, bus.out_result}, 32'h0);
    check("rst_out_flags", {28'b0, bus.out_flags}, 32'h0);
    check("rst_ovf_count", {24'b0, ovf_count}, 32'd0);
    #9 rst_n = 1'b1;

    // ADD with signed overflow
    drive(1'b1, ADD, 16'h8000, 1'b0, 1'b1);
    tick();
    drive(1'b0, ADD, 16'h0, 1'b0, 1'b0);
    check("add_valid", {31'b0, bus.out_valid}, 32'd1);
    check("add_result", {16'b0, bus.out_result}, 32'h8000);
    check("add_flags", {28'b0, bus.out_flags}, 32'b1001);
    check("add_ovf", {24'b0, ovf_count}, 32'd1);

    // AND: adder flags masked
    drive(1'b1, AND, 16'h8000, 1'b1, 1'b1);
    tick();
    drive(1'b0, ADD, 16'h0, 1'b0, 1'b0);
    check("and_result", {16'b0, bus.out_result}, 32'h8000);
    check("and_flags", {28'b0, bus.out_flags}, 32'b0000);
    check("and_ovf", {24'b0, ovf_count}, 32'd1);

    // XOR zero, then opcode 111 zero with carry/overflow raised
    drive(1'b1, XOR, 16'h0000, 1'b0, 1'b0);
    tick();
    check("xor_flags", {28'b0, bus.out_flags}, 32'b0100);
    drive(1'b1, 3'b111, 16'h0000, 1'b1, 1'b1);
    tick();
    drive(1'b0, ADD, 16'h0, 1'b0, 1'b0);
    check("op111_flags", {28'b0, bus.out_flags}, 32'b0100);
    check("op111_ovf", {24'b0, ovf_count}, 32'd1);
    tick();
    check("drain_valid", {31'b0, bus.out_valid}, 32'd0);

    // Back-pressure: three pushes with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, OR, 16'h0001, 1'b0, 1'b0);
    tick();
    check("bp1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("bp1_head", {16'b0, bus.out_result}, 32'h0001);
    drive(1'b1, OR, 16'h0002, 1'b0, 1'b0);
    tick();
    check("bp2_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("bp2_head", {16'b0, bus.out_result}, 32'h0001);
    drive(1'b1, OR, 16'h0003, 1'b0, 1'b0);
    tick();
    check("bp3_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("bp3_head", {16'b0, bus.out_result}, 32'h0001);
    tick();
    check("bp4_head", {16'b0, bus.out_result}, 32'h0001);
    check("bp4_flags", {28'b0, bus.out_flags}, 32'b0000);
    bus.out_ready = 1'b1;
    tick();
    check("bp5_head", {16'b0, bus.out_result}, 32'h0002);
    check("bp5_in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, ADD, 16'h0, 1'b0, 1'b0);
    check("bp6_head", {16'b0, bus.out_result}, 32'h0003);
    check("bp6_valid", {31'b0, bus.out_valid}, 32'd1);
    tick();
    check("bp7_valid", {31'b0, bus.out_valid}, 32'd0);

    // Overflow counter saturation and clear priority
    drive(1'b1, SUB, 16'h7fff, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    check("sat_partial", {24'b0, ovf_count}, 32'd11);
    check("sub_flags", {28'b0, bus.out_flags}, 32'b0011);
    for (int i = 0; i < 290; i++) tick();
    check("sat_max", {24'b0, ovf_count}, 32'd255);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    drive(1'b0, ADD, 16'h0, 1'b0, 1'b0);
    check("clear_prio", {24'b0, ovf_count}, 32'd0);
    tick();

    // Asynchronous reset while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, ADD, 16'h0005, 1'b0, 1'b0);
    tick();
    drive(1'b1, ADD, 16'h0006, 1'b0, 1'b0);
    tick();
    drive(1'b0, ADD, 16'h0, 1'b0, 1'b0);
    check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("arst_out_result", {16'b0, bus.out_result}, 32'h0);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, ADD, 16'h00AA, 1'b0, 1'b0);
    tick();
    drive(1'b0, ADD, 16'h0, 1'b0, 1'b0);
    check("post_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    check("post_rst_result", {16'b0, bus.out_result}, 32'h00AA);
    check("post_rst_flags", {28'b0, bus.out_flags}, 32'b0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
